// File: rtl/posi_satd_cost_accumulator.sv
// Post-intra SATD back end: abs, 16-lane sum, HM-style rounding per
// transform, and per-prediction-block cost accumulation.
module posi_satd_cost_accumulator #(
   parameter int DATA_WIDTH = 16,
   parameter int COST_WIDTH = 20
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [1:0]                 size_i,
   input  logic                       val_i,
   input  logic [DATA_WIDTH*16-1:0]   dat_i,
   output logic                       val_o,
   output logic [COST_WIDTH-1:0]      cost_o
);

   localparam int SW = DATA_WIDTH + 4;
   localparam int TW = DATA_WIDTH + 6;
   localparam int AW = DATA_WIDTH + 10;

   logic [5:0]            cnt_r;
   logic [1:0]            blk_size_r;
   logic [1:0]            cur_size;
   logic [5:0]            last_cnt;
   logic                  is4, last_sub, last_blk, first_blk;

   logic [DATA_WIDTH-1:0] lane_abs [16];
   logic [DATA_WIDTH-1:0] s1_abs   [16];
   logic                  s1_val, s1_first, s1_lsub, s1_lblk, s1_is4;

   logic [SW-1:0]         sum16;
   logic [SW-1:0]         s2_sum;
   logic                  s2_val, s2_first, s2_lsub, s2_lblk, s2_is4;

   logic [TW-1:0]         sub_acc_r, sub_total;
   logic [AW-1:0]         acc_r, sub_norm, acc_next;
   logic [COST_WIDTH-1:0] cost_sat;

   // size_i only matters on the first beat; afterwards the latched size rules
   always_comb begin
      cur_size = (cnt_r == 6'd0) ? size_i : blk_size_r;
      case (cur_size)
         2'd0:    last_cnt = 6'd0;
         2'd1:    last_cnt = 6'd3;
         2'd2:    last_cnt = 6'd15;
         default: last_cnt = 6'd63;
      endcase
      is4       = (cur_size == 2'd0);
      last_blk  = (cnt_r == last_cnt);
      last_sub  = is4 | (cnt_r[1:0] == 2'b11);
      first_blk = (cnt_r[5:2] == 4'd0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r      <= '0;
         blk_size_r <= '0;
      end else if (val_i) begin
         if (cnt_r == 6'd0) blk_size_r <= size_i;
         cnt_r <= last_blk ? 6'd0 : cnt_r + 6'd1;
      end
   end

   // two's-complement negate of the most negative value lands on 2^(DW-1)
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         logic [DATA_WIDTH-1:0] lane;
         lane = dat_i[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
         lane_abs[i] = lane[DATA_WIDTH-1] ? (~lane + 1'b1) : lane;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_val   <= 1'b0;
         s1_first <= 1'b0;
         s1_lsub  <= 1'b0;
         s1_lblk  <= 1'b0;
         s1_is4   <= 1'b0;
         for (int i = 0; i < 16; i++) s1_abs[i] <= '0;
      end else begin
         s1_val <= val_i;
         if (val_i) begin
            s1_first <= first_blk;
            s1_lsub  <= last_sub;
            s1_lblk  <= last_blk;
            s1_is4   <= is4;
            for (int i = 0; i < 16; i++) s1_abs[i] <= lane_abs[i];
         end
      end
   end

   always_comb begin
      sum16 = '0;
      for (int i = 0; i < 16; i++) sum16 = sum16 + SW'(s1_abs[i]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_val   <= 1'b0;
         s2_first <= 1'b0;
         s2_lsub  <= 1'b0;
         s2_lblk  <= 1'b0;
         s2_is4   <= 1'b0;
         s2_sum   <= '0;
      end else begin
         s2_val <= s1_val;
         if (s1_val) begin
            s2_first <= s1_first;
            s2_lsub  <= s1_lsub;
            s2_lblk  <= s1_lblk;
            s2_is4   <= s1_is4;
            s2_sum   <= sum16;
         end
      end
   end

   // round each transform on its own before it joins the block total
   always_comb begin
      sub_total = sub_acc_r + TW'(s2_sum);
      sub_norm  = s2_is4 ? (AW'(s2_sum) + AW'(1)) >> 1
                         : (AW'(sub_total) + AW'(2)) >> 2;
      acc_next  = (s2_first ? '0 : acc_r) + sub_norm;
      cost_sat  = (|acc_next[AW-1:COST_WIDTH]) ? {COST_WIDTH{1'b1}}
                                               : acc_next[COST_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sub_acc_r <= '0;
         acc_r     <= '0;
         val_o     <= 1'b0;
         cost_o    <= '0;
      end else begin
         val_o <= s2_val & s2_lblk;
         if (s2_val) begin
            sub_acc_r <= s2_lsub ? '0 : sub_total;
            if (s2_lsub) acc_r <= acc_next;
            if (s2_lblk) cost_o <= cost_sat;
         end
      end
   end

endmodule

// File: tb/tb_posi_satd_cost_accumulator.sv
// Bench for posi_satd_cost_accumulator: directed table, corner sequences
// and random blocks against an arithmetic cost model with a scoreboard.
module tb_posi_satd_cost_accumulator;

   localparam int MAXC = 1048575;

   logic         clk = 1'b0;
   logic         rstn;
   logic [1:0]   size_i;
   logic         val_i;
   logic [255:0] dat_i;
   logic         val_o;
   logic [19:0]  cost_o;

   posi_satd_cost_accumulator #(.DATA_WIDTH(16), .COST_WIDTH(20)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .size_i (size_i),
      .val_i  (val_i),
      .dat_i  (dat_i),
      .val_o  (val_o),
      .cost_o (cost_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cost;
      int due;
   } exp_t;

   typedef struct {
      int size;
      int fill;
      int gap_at;
      int gap_len;
      int tog;
      int cost;
   } vec_t;

   exp_t q[$];
   int   bufv [64][16];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   last_cost = 0;

   always @(negedge clk) begin
      if (!rstn) begin
         last_cost = 0;
         n_chk++;
         if (val_o !== 1'b0 || cost_o !== 20'd0) begin
            n_fail++;
            $display("FAIL reset val_o=%b cost_o=%0d want 0/0", val_o, cost_o);
         end
      end else if (val_o === 1'b1) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious val_o cyc=%0d cost=%0d", cyc, cost_o);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.due != cyc || cost_o !== 20'(e.cost)) begin
               n_fail++;
               $display("FAIL cost cyc=%0d got=%0d want cyc=%0d cost=%0d",
                        cyc, cost_o, e.due, e.cost);
            end
            last_cost = e.cost;
         end
      end else begin
         n_chk++;
         if (cost_o !== 20'(last_cost)) begin
            n_fail++;
            $display("FAIL hold cyc=%0d got=%0d want=%0d", cyc, cost_o, last_cost);
         end
         if (q.size() > 0 && q[0].due <= cyc) begin
            n_fail++;
            $display("FAIL missing val_o cyc=%0d want cost=%0d", cyc, q[0].cost);
            void'(q.pop_front());
         end
      end
   end

   task automatic idle();
      val_i  = 1'b0;
      size_i = 2'($urandom_range(0, 3));
      dat_i  = {8{$urandom}};
      @(posedge clk);
      #1;
   endtask

   // tog: 0 keep size, 1 drive 0 after first beat, 2 random after first beat
   task automatic drive_blk(input int size, input int nlim, input int gap_at,
                            input int gap_len, input int tog, input int rgap,
                            output int lc);
      int nb;
      logic [255:0] d;
      nb = 1 << (2 * size);
      if (nlim < nb) nb = nlim;
      lc = 0;
      for (int b = 0; b < nb; b++) begin
         if (b == gap_at) repeat (gap_len) idle();
         if (rgap != 0 && b > 0 && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) idle();
         for (int i = 0; i < 16; i++) d[16*(16-i)-1 -: 16] = 16'(bufv[b][i]);
         if (b == 0 || tog == 0) size_i = 2'(size);
         else if (tog == 1)      size_i = 2'd0;
         else                    size_i = 2'($urandom_range(0, 3));
         val_i = 1'b1;
         dat_i = d;
         lc = cyc;
         @(posedge clk);
         #1;
      end
      val_i = 1'b0;
   endtask

   function automatic int model_cost(input int size);
      longint c, s;
      int nb;
      nb = 1 << (2 * size);
      c = 0;
      if (size == 0) begin
         s = 0;
         for (int i = 0; i < 16; i++) s += (bufv[0][i] < 0) ? -bufv[0][i] : bufv[0][i];
         c = (s + 1) / 2;
      end else begin
         for (int g = 0; g < nb / 4; g++) begin
            s = 0;
            for (int b = 4 * g; b < 4 * g + 4; b++)
               for (int i = 0; i < 16; i++)
                  s += (bufv[b][i] < 0) ? -bufv[b][i] : bufv[b][i];
            c += (s + 2) / 4;
         end
      end
      return (c > MAXC) ? MAXC : int'(c);
   endfunction

   task automatic fill(input int v);
      for (int b = 0; b < 64; b++)
         for (int i = 0; i < 16; i++) bufv[b][i] = v;
   endtask

   function automatic int rnd_lane(input int mode);
      int k;
      case (mode)
         0: return int'($urandom_range(0, 65535)) - 32768;
         1: return int'($urandom_range(0, 16)) - 8;
         2: return -32768;
         default: begin
            k = int'($urandom_range(0, 2));
            return (k == 0) ? -32768 : (k == 1) ? 32767 : 0;
         end
      endcase
   endfunction

   initial begin
      vec_t tbl[7];
      exp_t e;
      int   lc, sz, md;

      tbl[0] = '{0, -3, -1, 0, 0, 24};
      tbl[1] = '{1, 5, 2, 2, 1, 80};
      tbl[2] = '{2, 1, -1, 0, 0, 64};
      tbl[3] = '{1, 2, -1, 0, 0, 32};
      tbl[4] = '{0, 1, -1, 0, 0, 8};
      tbl[5] = '{3, -32768, -1, 0, 0, MAXC};
      tbl[6] = '{0, 7, -1, 0, 0, 56};

      rstn = 1'b0;
      val_i = 1'b0;
      size_i = 2'd0;
      dat_i = '0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      idle();

      foreach (tbl[k]) begin
         fill(tbl[k].fill);
         drive_blk(tbl[k].size, 64, tbl[k].gap_at, tbl[k].gap_len,
                   tbl[k].tog, 0, lc);
         e.cost = tbl[k].cost;
         e.due  = lc + 3;
         q.push_back(e);
      end
      repeat (5) idle();

      // 16x16 where each 8x8 sums to 65: per-8x8 rounding gives 4*16
      fill(1);
      for (int g = 0; g < 4; g++) bufv[4*g][0] = 2;
      drive_blk(2, 64, -1, 0, 0, 0, lc);
      e.cost = 64;
      e.due  = lc + 3;
      q.push_back(e);
      repeat (5) idle();

      // reset mid-block: partial 8x8 must vanish
      fill(9);
      drive_blk(1, 2, -1, 0, 0, 0, lc);
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      fill(7);
      drive_blk(0, 64, -1, 0, 0, 0, lc);
      e.cost = 56;
      e.due  = lc + 3;
      q.push_back(e);
      repeat (5) idle();

      for (int n = 0; n < 40; n++) begin
         sz = int'($urandom_range(0, 3));
         md = int'($urandom_range(0, 3));
         for (int b = 0; b < 64; b++)
            for (int i = 0; i < 16; i++) bufv[b][i] = rnd_lane(md);
         drive_blk(sz, 64, -1, 0, 2, n % 2, lc);
         e.cost = model_cost(sz);
         e.due  = lc + 3;
         q.push_back(e);
         if ($urandom_range(0, 2) == 0) idle();
      end

      for (int k = 0; k < 50 && q.size() > 0; k++) idle();
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      repeat (3) idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/posi_satd_cost_accumulator.md
# posi_satd_cost_accumulator

Back end of the post-intra SATD cost path. Consumes the 16-lane, two-row/two-column coefficient beats from the second Hadamard stage, which sits after the transpose buffer. Sums absolute values per 8x8 (or 4x4) transform and applies HM-style normalization. Accumulates sub-block SATDs into one cost per prediction block of size 4/8/16/32. The emitted cost feeds mode decision.

## Interface
- DATA_WIDTH, 16, signed width of each coefficient lane
- COST_WIDTH, 20, unsigned width of the output cost (saturating)
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- size_i  input  2  block size, `SIZE_04=0, `SIZE_08=1, `SIZE_16=2, `SIZE_32=3; sampled on the first beat of a block only
- val_i  input  1  coefficient beat valid
- dat_i  input  DATA_WIDTH*16  16 signed two's-complement lanes, lane 0 in the MSBs
- val_o  output  1  one-cycle pulse, cost_o valid
- cost_o  output  COST_WIDTH  SATD cost of the completed block, held until next val_o

## Operation
- Beats per block: SIZE_04 1, SIZE_08 4, SIZE_16 16, SIZE_32 64. For SIZE_04 one beat is one complete 4x4. Otherwise every 4 consecutive beats form one 8x8 sub-block.
- Beat counter cnt_r (6 bit) increments on each val_i. It is cleared when it reaches beats-1 for the latched size.
- Latched size blk_size_r is loaded when val_i && cnt_r==0. A change on size_i mid-block is ignored.
- val_i low between beats is allowed. cnt_r, blk_size_r and the partial sums hold.
- Stage 1: per-lane abs. The most negative input 2^(DATA_WIDTH-1) maps to +2^(DATA_WIDTH-1), unsigned DATA_WIDTH bits, with no overflow. Tags first_blk, last_sub, last_blk, is4 travel with the data.
- Stage 2: 16-lane adder tree registered to sum16 (DATA_WIDTH+4 bits). sub_acc accumulates sum16 across the 4 beats of an 8x8 and restarts at each sub-block.
- Stage 3, normalization:
  - SIZE_04: sub = (sum16+1)>>1.
  - Others at last_sub: sub = (sub_total+2)>>2.
  - Rounding is applied per 8x8 before summing sub-blocks, never to the block total.
- Block accumulator: acc = (first_blk ? 0 : acc) + sub, DATA_WIDTH+10 bits wide, so back-to-back blocks need no idle cycle.
- Output at last_blk: cost_o = min(acc_next, 2^COST_WIDTH-1). val_o pulses for 1 cycle.
- No backpressure. The block accepts one beat per cycle indefinitely.

## Timing
- Reset: cnt_r=0, blk_size_r=0, all pipeline regs and tags 0, val_o=0, cost_o=0.
- Latency: if the final beat of a block is presented in cycle t, val_o=1 and cost_o is valid in cycle t+3.
- Throughput: one beat per cycle. A SIZE_04 block every cycle gives val_o every cycle, with cost_o updated each cycle.
- The new block's first beat may arrive in cycle t+1 after the previous block's last beat. first_blk ensures no carry-over between blocks.
- Reset asserted mid-block discards all partial state. No val_o is produced for the interrupted block. The first beat after reset release starts a new block.
- cost_o holds its value between val_o pulses. It is never cleared except by reset.
- Saturation applies only at the output. The internal acc width covers 64 beats of full-scale input without wrap.

## Test plan
- 4x4: one beat, size_i=0, all lanes -3 -> sum 48, cost_o=24, val_o in cycle t+3 only.
- 8x8 with gaps: 4 beats, all lanes 5, val_i low 2 cycles between beats 2 and 3 -> cost_o=(320+2)>>2=80, 3 cycles after beat 4; size_i toggled to 0 mid-block has no effect.
- 16x16 rounding: 16 beats, all lanes 1 -> each 8x8 gives 64 -> 16, cost_o=64. A variant where each 8x8 sums to 65 gives 16 per sub-block, so cost_o=64, not (260+2)>>2=65.
- Back-to-back: a SIZE_08 block (all 2, cost 32) immediately followed by a SIZE_04 block (all 1, cost 8) -> val_o pulses in consecutive-spaced cycles with 32 then 8; no leakage between blocks.
- Saturation: SIZE_32, 64 beats, all lanes -32768 -> true total 2^23, cost_o=1048575.
- Reset mid-block: rstn low after beat 2 of a SIZE_08 block -> no val_o. A following 4x4 block of all 7 gives cost_o=56.
